// File: rtl/alu32_pkg.sv
// alu32_pkg: opcode and status encodings shared by the alu32 block and its
// multiplier, plus the Booth iteration count.
package alu32_pkg;

  // Operation select
  localparam logic [3:0] OP_NOTA = 4'h0;
  localparam logic [3:0] OP_NOTB = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_XNOR = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SGT  = 4'h7;
  localparam logic [3:0] OP_LSL  = 4'h8;
  localparam logic [3:0] OP_LSR  = 4'h9;
  localparam logic [3:0] OP_ASR  = 4'hA;
  localparam logic [3:0] OP_ADD  = 4'hB;
  localparam logic [3:0] OP_SUB  = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;

  // Completion status
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam logic [1:0] ST_HOLD = 2'b11;

  // Radix-4 Booth: two multiplier bits retired per iteration
  localparam int MUL_ITERS = 16;

  // Opcodes 0..C complete in the accepting cycle
  function automatic logic is_single_cycle(input logic [3:0] op);
    return op <= OP_SUB;
  endfunction

endpackage

// File: rtl/alu32_booth_mul.sv
// alu32_booth_mul: iterative signed 32x32 radix-4 Booth multiplier.
// Only compiled when ALU32_MUL_EN is defined.
// After start, 16 iteration edges follow; done is then raised for one cycle
// and busy drops on the edge that consumes the product.
`ifdef ALU32_MUL_EN
module alu32_booth_mul
  import alu32_pkg::*;
(
  input  logic               clk,
  input  logic               clear_i,
  input  logic               start_i,
  input  logic signed [31:0] a_i,
  input  logic signed [31:0] b_i,
  output logic               busy_o,
  output logic signed [63:0] product_o,
  output logic               done_o
);

  logic               busy_q, busy_d;
  logic [4:0]         cnt_q, cnt_d;
  logic signed [63:0] mcand_q, mcand_d;
  logic [32:0]        mplr_q, mplr_d;
  logic signed [63:0] acc_q, acc_d;
  logic signed [63:0] pp;
  logic               last;

  assign last = (cnt_q == 5'(MUL_ITERS));

  // Booth digit select from the current 3-bit multiplier window
  always_comb begin
    case (mplr_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q <<< 1;
      3'b100:         pp = -(mcand_q <<< 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  // Iteration control and datapath next state
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    if (busy_q) begin
      if (last) begin
        busy_d = 1'b0;
      end else begin
        acc_d   = acc_q + pp;
        mcand_d = mcand_q <<< 2;
        mplr_d  = {2'b00, mplr_q[32:2]};
        cnt_d   = cnt_q + 5'd1;
      end
    end else if (start_i) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      mcand_d = {{32{a_i[31]}}, a_i};
      mplr_d  = {b_i, 1'b0};
      acc_d   = '0;
    end
  end

  // Control registers: cleared by reset or abort
  always_ff @(posedge clk) begin
    if (clear_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Datapath registers: reloaded on every start
  always_ff @(posedge clk) begin
    mcand_q <= mcand_d;
    mplr_q  <= mplr_d;
    acc_q   <= acc_d;
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && last;
  assign product_o = acc_q;

endmodule
`endif

// File: rtl/alu32.sv
// alu32: execute-stage ALU with registered results and completion status.
// Define ALU32_MUL_EN to build in the multi-cycle Booth multiplier (opcode D);
// without it, opcode D is treated as reserved.
module alu32
  import alu32_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  opcode,
  input  logic        op_clear,
  input  logic        op_start,
  input  logic [1:0]  op_done_before,
  input  logic [31:0] result1_before,
  input  logic [31:0] result2_before,
  output logic [31:0] result1,
  output logic [31:0] result2,
  output logic [1:0]  op_done
);

  logic [31:0] r1_q, r1_d;
  logic [31:0] r2_q, r2_d;
  logic [1:0]  st_q, st_d;
  logic [31:0] alu_r1, alu_r2;
  logic [32:0] add_w;
  logic        accept;
  logic        mul_busy, mul_done;
  logic [63:0] mul_prod;

  assign add_w  = {1'b0, a} + {1'b0, b};
  assign accept = op_start && ((op_done_before == ST_IDLE) || (op_done_before == ST_DONE));

`ifdef ALU32_MUL_EN
  logic mul_start;

  alu32_booth_mul u_mul (
    .clk       (clk),
    .clear_i   (reset_n | op_clear),
    .start_i   (mul_start),
    .a_i       ($signed(a)),
    .b_i       ($signed(b)),
    .busy_o    (mul_busy),
    .product_o (mul_prod),
    .done_o    (mul_done)
  );
`else
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  // Single-cycle result computation
  always_comb begin
    alu_r1 = '0;
    alu_r2 = '0;
    case (opcode)
      OP_NOTA: alu_r1 = ~a;
      OP_NOTB: alu_r1 = ~b;
      OP_AND:  alu_r1 = a & b;
      OP_OR:   alu_r1 = a | b;
      OP_XOR:  alu_r1 = a ^ b;
      OP_XNOR: alu_r1 = ~(a ^ b);
      OP_SLT:  alu_r1 = {31'b0, $signed(a) < $signed(b)};
      OP_SGT:  alu_r1 = {31'b0, $signed(a) > $signed(b)};
      OP_LSL:  alu_r1 = a << b[4:0];
      OP_LSR:  alu_r1 = a >> b[4:0];
      OP_ASR:  alu_r1 = $signed(a) >>> b[4:0];
      OP_ADD: begin
        alu_r1 = add_w[31:0];
        alu_r2 = {31'b0, add_w[32]};
      end
      OP_SUB: begin
        alu_r1 = a - b;
        alu_r2 = {31'b0, a < b};
      end
      default: ;
    endcase
  end

  // Next-state selection: clear, running multiply, accept, else pass-through
  always_comb begin
    r1_d = result1_before;
    r2_d = result2_before;
    st_d = op_done_before;
`ifdef ALU32_MUL_EN
    mul_start = 1'b0;
`endif
    if (op_clear) begin
      r1_d = '0;
      r2_d = '0;
      st_d = ST_IDLE;
    end else if (mul_busy) begin
      if (mul_done) begin
        {r2_d, r1_d} = mul_prod;
        st_d = ST_DONE;
      end else begin
        r1_d = r1_q;
        r2_d = r2_q;
        st_d = ST_BUSY;
      end
    end else if (accept) begin
      if (is_single_cycle(opcode)) begin
        r1_d = alu_r1;
        r2_d = alu_r2;
        st_d = ST_DONE;
      end
`ifdef ALU32_MUL_EN
      else if (opcode == OP_MUL) begin
        mul_start = 1'b1;
        r1_d = r1_q;
        r2_d = r2_q;
        st_d = ST_BUSY;
      end
`endif
      else begin
        st_d = ST_IDLE;
      end
    end
  end

  // Output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r1_q <= '0;
      r2_q <= '0;
      st_q <= ST_IDLE;
    end else begin
      r1_q <= r1_d;
      r2_q <= r2_d;
      st_q <= st_d;
    end
  end

  assign result1 = r1_q;
  assign result2 = r2_q;
  assign op_done = st_q;

endmodule

// File: tb/tb_alu32.sv
// tb_alu32: randomized self-checking bench for alu32 with a behavioural model.
// Follows ALU32_MUL_EN so the model matches the build under test.
module tb_alu32;

`ifdef ALU32_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] a, b;
  logic [3:0]  opcode;
  logic        op_clear, op_start;
  logic [1:0]  op_done_before;
  logic [31:0] result1_before, result2_before;
  logic [31:0] result1, result2;
  logic [1:0]  op_done;

  int errors = 0;
  int checks = 0;

  // model state
  logic [31:0] m_r1 = '0, m_r2 = '0;
  logic [1:0]  m_st = '0;
  int          m_left = 0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_tmp;

  always #5 clk = ~clk;

  alu32 dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .a              (a),
    .b              (b),
    .opcode         (opcode),
    .op_clear       (op_clear),
    .op_start       (op_start),
    .op_done_before (op_done_before),
    .result1_before (result1_before),
    .result2_before (result2_before),
    .result1        (result1),
    .result2        (result2),
    .op_done        (op_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {result2, result1} of a single-cycle opcode from plain arithmetic
  function automatic logic [63:0] single_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    longint          sx;
    longint unsigned s;
    int              sh;
    sh = int'(y % 32);
    case (op)
      4'h0: return {32'h0, ~x};
      4'h1: return {32'h0, ~y};
      4'h2: return {32'h0, x & y};
      4'h3: return {32'h0, x | y};
      4'h4: return {32'h0, x ^ y};
      4'h5: return {32'h0, ~(x ^ y)};
      4'h6: return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      4'h7: return ($signed(x) > $signed(y)) ? 64'd1 : 64'd0;
      4'h8: return {32'h0, 32'(longint'(x) * (longint'(1) << sh))};
      4'h9: return {32'h0, 32'(longint'(x) / (longint'(1) << sh))};
      4'hA: begin
        sx = longint'($signed(x));
        return {32'h0, 32'(sx >>> sh)};
      end
      4'hB: begin
        s = longint'(x) + longint'(y);
        return s;
      end
      4'hC: return {31'h0, (x < y), x - y};
      default: return 64'h0;
    endcase
  endfunction

  // Model update and compare on every edge
  always @(posedge clk) begin
    if (reset_n || op_clear) begin
      m_r1 = '0; m_r2 = '0; m_st = 2'b00; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        {m_r2, m_r1} = m_prod;
        m_st = 2'b10;
      end else begin
        m_st = 2'b01;
      end
    end else if (op_start && (op_done_before == 2'b00 || op_done_before == 2'b10)) begin
      if (opcode <= 4'hC) begin
        m_tmp = single_op(opcode, a, b);
        {m_r2, m_r1} = m_tmp;
        m_st = 2'b10;
      end else if (opcode == 4'hD && MUL_EN) begin
        m_prod = 64'(longint'($signed(a)) * longint'($signed(b)));
        m_left = 17;
        m_st = 2'b01;
      end else begin
        m_r1 = result1_before; m_r2 = result2_before; m_st = 2'b00;
      end
    end else begin
      m_r1 = result1_before; m_r2 = result2_before; m_st = op_done_before;
    end
    #1;
    check("model_result1", result1, m_r1);
    check("model_result2", result2, m_r2);
    check("model_op_done", {30'h0, op_done}, {30'h0, m_st});
  end

  task automatic drive(input logic rst, input logic clr, input logic st, input logic [3:0] op,
                       input logic [31:0] x, input logic [31:0] y, input logic [1:0] db,
                       input logic [31:0] r1b, input logic [31:0] r2b);
    @(negedge clk);
    reset_n = rst; op_clear = clr; op_start = st; opcode = op;
    a = x; b = y; op_done_before = db; result1_before = r1b; result2_before = r2b;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [3:0]  t_op [7] = '{4'h0, 4'h2, 4'h4, 4'h6, 4'h7, 4'hB, 4'hC};
  logic [31:0] t_r1 [7] = '{32'hFFFFEFFF, 32'h00001000, 32'h00100000, 32'h1, 32'h0, 32'h00102000, 32'hFFF00000};
  logic [31:0] t_r2 [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
  logic [3:0]  s_op [3] = '{4'h8, 4'h9, 4'hA};
  logic [31:0] s_r1 [3] = '{32'h00000010, 32'h08000000, 32'hF8000000};

  initial begin
    reset_n = 1'b1; op_clear = 1'b0; op_start = 1'b0; opcode = 4'h0;
    a = '0; b = '0; op_done_before = 2'b00; result1_before = '0; result2_before = '0;

    // reset released, idle hold of zeros
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0);
    check("reset_r1", result1, 32'h0);
    check("reset_r2", result2, 32'h0);
    check("reset_st", {30'h0, op_done}, 32'h0);

    // start refused while status is HOLD
    drive(1'b0, 1'b0, 1'b1, 4'h2, 32'h00001000, 32'h00101000, 2'b11, 32'h12345678, 32'h87654321);
    check("hold_r1", result1, 32'h12345678);
    check("hold_r2", result2, 32'h87654321);
    check("hold_st", {30'h0, op_done}, 32'h3);

    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b1, t_op[i], 32'h00001000, 32'h00101000, 2'b00, 32'h0, 32'h0);
      check($sformatf("op%0h_r1", t_op[i]), result1, t_r1[i]);
      check($sformatf("op%0h_r2", t_op[i]), result2, t_r2[i]);
      check($sformatf("op%0h_st", t_op[i]), {30'h0, op_done}, 32'h2);
    end

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, s_op[i], 32'h80000001, 32'h4, 2'b00, 32'h0, 32'h0);
      check($sformatf("shift%0h_r1", s_op[i]), result1, s_r1[i]);
    end

    // multiply 0x1000 * 0x101000
    drive(1'b0, 1'b0, 1'b1, 4'hD, 32'h00001000, 32'h00101000, 2'b00, 32'hAAAA5555, 32'h5555AAAA);
`ifdef ALU32_MUL_EN
    check("mul_accept_st", {30'h0, op_done}, 32'h1);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b0, 1'b0, 4'h0, $urandom, $urandom, 2'b10, $urandom, $urandom);
      check("mul_busy_st", {30'h0, op_done}, 32'h1);
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'b10, 32'h0, 32'h0);
    check("mul_r2", result2, 32'h00000001);
    check("mul_r1", result1, 32'h01000000);
    check("mul_st", {30'h0, op_done}, 32'h2);
`else
    check("mul_reserved_r1", result1, 32'hAAAA5555);
    check("mul_reserved_st", {30'h0, op_done}, 32'h0);
`endif

    // abort a multiply with op_clear on its 5th busy cycle
    drive(1'b0, 1'b0, 1'b1, 4'hD, 32'h7FFFFFFF, 32'h80000000, 2'b10, result1, result2);
    for (int k = 0; k < 3; k++)
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'b10, 32'h1, 32'h1);
    drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 2'b10, 32'h1, 32'h1);
    check("abort_r1", result1, 32'h0);
    check("abort_r2", result2, 32'h0);
    check("abort_st", {30'h0, op_done}, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 4'h3, 32'h00001000, 32'h00101000, 2'b00, 32'h0, 32'h0);
    check("after_abort_r1", result1, 32'h00101000);
    check("after_abort_st", {30'h0, op_done}, 32'h2);

    // randomized traffic with mostly-faithful feedback
    for (int n = 0; n < 1500; n++) begin
      logic        rst, clr, st;
      logic [1:0]  db;
      logic [31:0] r1b, r2b;
      rst = ($urandom_range(0, 99) < 2);
      clr = ($urandom_range(0, 99) < 3);
      st  = ($urandom_range(0, 3) != 0);
      db  = ($urandom_range(0, 4) == 0) ? 2'($urandom) : m_st;
      r1b = ($urandom_range(0, 3) == 0) ? $urandom : m_r1;
      r2b = ($urandom_range(0, 3) == 0) ? $urandom : m_r2;
      drive(rst, clr, st, 4'($urandom_range(0, 15)), pick(), pick(), db, r1b, r2b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
